testing_wb_slave: RTL and testbench
===================================

TESTING_WB_SLAVE -- requirements
Module: testing_wb_slave

Interface
REQ-001 Parameter dw, default 32: data bus width.
REQ-002 Parameter aw, default 32: address bus width.
REQ-003 wb_clk  in  1  single system clock; all logic on rising edge.
REQ-004 wb_rst  in  1  reset; synchronous, active-high.
REQ-005 wb_adr_i  in  aw  byte address; bits [3:2] select register, all other bits ignored.
REQ-006 wb_dat_i  in  dw  write data.
REQ-007 wb_sel_i  in  dw/8  byte-lane enables; bit n covers data bits [8n+7:8n].
REQ-008 wb_we_i  in  1  1 = write, 0 = read.
REQ-009 wb_cyc_i  in  1  bus cycle active.
REQ-010 wb_stb_i  in  1  strobe; transfer request valid.
REQ-011 wb_cti_i  in  3  cycle type: 000 classic, 001 constant burst, 010 incrementing burst, 111 end of burst.
REQ-012 wb_bte_i  in  2  burst type; accepted, no effect.
REQ-013 wb_dat_o  out  dw  read data.
REQ-014 wb_ack_o  out  1  transfer acknowledge.
REQ-015 wb_err_o  out  1  error; constant 0.
REQ-016 wb_rty_o  out  1  retry; constant 0.

Function
REQ-017 The block SHALL contain four dw-bit registers, REG0..REG3, at byte offsets 0x0, 0x4, 0x8 and 0xC.
REQ-018 Request = wb_cyc_i & wb_stb_i; when there is no request, wb_ack_o SHALL be 0 on the next edge.
REQ-019 Classic cycle (cti 000, or 111): wb_ack_o SHALL rise one clock after the request is first seen, stay high for exactly one clock, then drop.
REQ-020 Classic cycle: a request still held in the cycle after an ack SHALL NOT be re-acked until wb_ack_o has been low for one cycle.
REQ-021 Burst cycle (cti 001/010): after the first ack, wb_ack_o SHALL stay high on every cycle the request remains asserted.
REQ-022 Burst cycle: an ack seen with cti = 111 SHALL end the burst; the next cycle SHALL follow classic rules.
REQ-023 Write: on an edge where wb_ack_o is high and wb_we_i = 1, each byte whose wb_sel_i bit is 1 SHALL be written from wb_dat_i into the addressed register; unselected bytes SHALL be unchanged.
REQ-024 Read: wb_dat_o SHALL present the full addressed register, independent of wb_sel_i, and SHALL be valid while wb_ack_o is high.
REQ-025 Read data SHALL be registered from the address sampled on the request edge.
REQ-026 A read in the cycle after a write to the same register SHALL return the new value.
REQ-027 When wb_ack_o is low, wb_dat_o SHALL hold its last value.
REQ-028 Addresses outside 0x0-0xC are aliased by adr[3:2]; no error SHALL be raised.
REQ-029 The block SHALL have no combinational path from any input to wb_ack_o.

Reset
REQ-030 While wb_rst = 1 at a clock edge: REG0..REG3 SHALL be 0, wb_dat_o SHALL be 0, wb_ack_o SHALL be 0, and burst state SHALL be cleared.
REQ-031 Reset asserted mid-transfer SHALL abort it; any write not yet acked is lost.
REQ-032 wb_err_o and wb_rty_o SHALL be 0 at all times, including during reset.

Structure
REQ-033 CTI encodings (CLASSIC, CONST, INCR, EOB) and the register offsets SHALL be constants in a shared package, wb_common_pkg.
REQ-034 The block is a single module with no sub-modules; the ack/burst control may optionally be split into wb_slave_ack_ctrl.

Verification
REQ-035 Scenario: reset, then read 0x0 -> data 0x00000000, ack for 1 cycle, err/rty 0.
REQ-036 Scenario: write 0xDEADBEEF, 0xF00DD00F, 0x01234567, 0x89ABCDEF to 0x0/0x4/0x8/0xC with sel F, then single reads -> same values returned in order.
REQ-037 Scenario: write 0x00000011 sel 1 to 0x0, then read with sel 1 -> 0xDEADBE11.
REQ-038 Scenario: sel 2 with data 0x00002200 -> read 0xDEAD2211; sel 4 with 0x00330000 -> 0xDE332211; sel 8 with 0x44000000 -> 0x44332211.
REQ-039 Scenario: incrementing burst of 4 reads from 0x0 ending with cti 111 -> ack high on 4 consecutive cycles, then low.
REQ-040 Scenario: assert wb_rst during a held classic write -> no register change, wb_ack_o 0, all registers 0.

Source files
------------

// File: rtl/wb_common_pkg.sv
// wb_common_pkg: shared Wishbone constants and helpers.
// CTI encodings, register byte offsets, burst test.
package wb_common_pkg;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_CONST   = 3'b001,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } cti_e;

  localparam int NUM_REGS = 4;

  localparam logic [3:0] REG0_OFF = 4'h0;
  localparam logic [3:0] REG1_OFF = 4'h4;
  localparam logic [3:0] REG2_OFF = 4'h8;
  localparam logic [3:0] REG3_OFF = 4'hC;

  function automatic logic is_burst(
    input logic [2:0] cti
  );
    return (cti == CTI_CONST) ||
           (cti == CTI_INCR);
  endfunction

endpackage

// File: rtl/wb_slave_ack_ctrl.sv
// wb_slave_ack_ctrl: registered Wishbone ack generator.
// In: clk, rst, req_i, cti_i. Out: ack_o (flop), ack_nxt_o (its D).
module wb_slave_ack_ctrl
  import wb_common_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_i,
  input  logic [2:0] cti_i,
  output logic       ack_o,
  output logic       ack_nxt_o
);

  logic ack_d;
  logic ack_q;

  // A fresh request is acked next cycle. Once acked,
  // only a burst cti keeps ack high; classic or EOB
  // forces one low cycle before the next ack.
  always_comb begin
    ack_d = 1'b0;
    if (req_i) begin
      ack_d = ack_q ? is_burst(cti_i) : 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
    end
  end

  assign ack_o     = ack_q;
  assign ack_nxt_o = ack_d;

endmodule

// File: rtl/testing_wb_slave.sv
// testing_wb_slave: four-register Wishbone slave, byte-lane writes.
// Ports: wb_clk/wb_rst, wb_*_i request side, wb_dat_o/ack/err/rty out.
module testing_wb_slave
  import wb_common_pkg::*;
#(
  parameter int dw = 32,
  parameter int aw = 32
) (
  input  logic            wb_clk,
  input  logic            wb_rst,
  input  logic [aw-1:0]   wb_adr_i,
  input  logic [dw-1:0]   wb_dat_i,
  input  logic [dw/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [dw-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o
);

  logic          req;
  logic          ack_q;
  logic          ack_nxt;
  logic [1:0]    idx;
  logic [dw-1:0] wr_mask;
  logic [dw-1:0] dat_d;
  logic [dw-1:0] dat_q;
  logic [dw-1:0] regs_d [NUM_REGS];
  logic [dw-1:0] regs_q [NUM_REGS];
  logic          unused_ok;

  assign req = wb_cyc_i & wb_stb_i;
  assign idx = wb_adr_i[3:2];

  // Burst type and non-select address bits have no effect.
  assign unused_ok = ^{wb_bte_i,
                       wb_adr_i[aw-1:4],
                       wb_adr_i[1:0]};

  wb_slave_ack_ctrl u_ack (
    .clk       (wb_clk),
    .rst       (wb_rst),
    .req_i     (req),
    .cti_i     (wb_cti_i),
    .ack_o     (ack_q),
    .ack_nxt_o (ack_nxt)
  );

  always_comb begin
    wr_mask = '0;
    for (int b = 0; b < dw/8; b++) begin
      wr_mask[8*b +: 8] = {8{wb_sel_i[b]}};
    end
    regs_d = regs_q;
    if (ack_q && wb_we_i) begin
      regs_d[idx] = (regs_q[idx] & ~wr_mask) |
                    (wb_dat_i & wr_mask);
    end
    // Read from next-state view so a write
    // committing this edge is forwarded.
    dat_d = ack_nxt ? regs_d[idx] : dat_q;
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      regs_q <= '{default: '0};
      dat_q  <= '0;
    end else begin
      regs_q <= regs_d;
      dat_q  <= dat_d;
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = 1'b0;
  assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_testing_wb_slave.sv
// tb_testing_wb_slave: directed + random bench for testing_wb_slave.
// Reference model is a word array updated by byte-mask arithmetic.
module tb_testing_wb_slave;
  import wb_common_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] dat_i = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic [2:0]  cti = 3'b000;
  logic [1:0]  bte = '0;
  logic [31:0] dat_o;
  logic        ack;
  logic        err;
  logic        rty;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [4];
  logic [31:0] rd;

  always #5 clk = ~clk;

  testing_wb_slave #(.dw(32), .aw(32)) dut (
    .wb_clk   (clk),
    .wb_rst   (rst),
    .wb_adr_i (adr),
    .wb_dat_i (dat_i),
    .wb_sel_i (sel),
    .wb_we_i  (we),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_cti_i (cti),
    .wb_bte_i (bte),
    .wb_dat_o (dat_o),
    .wb_ack_o (ack),
    .wb_err_o (err),
    .wb_rty_o (rty)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~m) | (d & m);
  endfunction

  // Classic single transfer; returns data seen with ack.
  task automatic classic(input logic        w,
                         input logic [31:0] a,
                         input logic [31:0] d,
                         input logic [3:0]  s,
                         output logic [31:0] r);
    int i;
    i = int'(a[3:2]);
    cyc = 1'b1; stb = 1'b1; we = w;
    adr = a; dat_i = d; sel = s;
    cti = (($urandom & 1) != 0) ? CTI_EOB : CTI_CLASSIC;
    bte = 2'($urandom_range(0, 3));
    chk("ack_no_comb", 32'(ack), 32'd0);
    tick();
    chk("ack_rise", 32'(ack), 32'd1);
    chk("err_rty", {30'd0, err, rty}, 32'd0);
    r = dat_o;
    if (!w) chk("rd_data", dat_o, mem[i]);
    tick();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("ack_drop", 32'(ack), 32'd0);
    if (w) mem[i] = merge(mem[i], d, s);
    else chk("rd_hold", dat_o, mem[i]);
  endtask

  task automatic burst(input int n,
                       input logic [2:0] ct,
                       input logic [31:0] a);
    cyc = 1'b1; stb = 1'b1; we = 1'b0;
    adr = a; cti = ct;
    for (int k = 1; k <= n; k++) begin
      tick();
      chk("burst_ack", 32'(ack), 32'd1);
      if (k == 1) chk("burst_d0", dat_o, mem[a[3:2]]);
      if (k == n) cti = CTI_EOB;
    end
    tick();
    cyc = 1'b0; stb = 1'b0; cti = CTI_CLASSIC;
    chk("burst_end", 32'(ack), 32'd0);
  endtask

  initial begin
    logic [31:0] wd [4];
    logic [31:0] ra;
    wd[0] = 32'hDEADBEEF; wd[1] = 32'hF00DD00F;
    wd[2] = 32'h01234567; wd[3] = 32'h89ABCDEF;
    for (int i = 0; i < 4; i++) mem[i] = '0;

    // reset state
    tick(); tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_err_rty", {30'd0, err, rty}, 32'd0);
    rst = 1'b0;
    tick();

    classic(1'b0, 32'h0, 32'h0, 4'hF, rd);
    chk("first_read", rd, 32'h0);

    for (int i = 0; i < 4; i++)
      classic(1'b1, 32'(i * 4), wd[i], 4'hF, rd);
    for (int i = 0; i < 4; i++) begin
      classic(1'b0, 32'(i * 4), 32'h0, 4'hF, rd);
      chk("rd_back", rd, wd[i]);
    end

    // byte lanes, read with narrow sel
    classic(1'b1, 32'h0, 32'h00000011, 4'h1, rd);
    classic(1'b0, 32'h0, 32'h0, 4'h1, rd);
    chk("sel1", rd, 32'hDEADBE11);
    classic(1'b1, 32'h0, 32'h00002200, 4'h2, rd);
    classic(1'b0, 32'h0, 32'h0, 4'h2, rd);
    chk("sel2", rd, 32'hDEAD2211);
    classic(1'b1, 32'h0, 32'h00330000, 4'h4, rd);
    classic(1'b0, 32'h0, 32'h0, 4'h4, rd);
    chk("sel4", rd, 32'hDE332211);
    classic(1'b1, 32'h0, 32'h44000000, 4'h8, rd);
    classic(1'b0, 32'h0, 32'h0, 4'h8, rd);
    chk("sel8", rd, 32'h44332211);

    // aliasing above 0xC
    classic(1'b0, 32'hFFFF_FF04, 32'h0, 4'h0, rd);
    chk("alias", rd, 32'hF00DD00F);

    // held classic read re-acks only after a low cycle
    cyc = 1'b1; stb = 1'b1; we = 1'b0;
    adr = 32'hC; cti = CTI_CLASSIC;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("held_ack", 32'(ack), 32'((k % 2) == 0));
    end
    cyc = 1'b0; stb = 1'b0;
    tick();
    chk("held_end", 32'(ack), 32'd0);

    burst(4, CTI_INCR, 32'h0);

    // randomized traffic
    for (int t = 0; t < 80; t++) begin
      ra = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3:
          classic(1'b1, ra, $urandom,
                  4'($urandom_range(0, 15)), rd);
        8, 9:
          burst($urandom_range(1, 5),
                (($urandom & 1) != 0) ? CTI_CONST : CTI_INCR,
                ra);
        default:
          classic(1'b0, ra, 32'h0,
                  4'($urandom_range(0, 15)), rd);
      endcase
      if (($urandom & 3) == 0) tick();
    end

    // make every register non-zero, then reset mid-write
    for (int i = 0; i < 4; i++)
      classic(1'b1, 32'(i * 4), wd[i], 4'hF, rd);
    cyc = 1'b1; stb = 1'b1; we = 1'b1;
    adr = 32'h4; dat_i = 32'hCAFEF00D; sel = 4'hF;
    cti = CTI_CLASSIC;
    tick();
    chk("mid_ack", 32'(ack), 32'd1);
    rst = 1'b1;
    tick();
    chk("rst_abort_ack", 32'(ack), 32'd0);
    chk("rst_abort_dat", dat_o, 32'd0);
    chk("rst_err_rty2", {30'd0, err, rty}, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    tick();
    for (int i = 0; i < 4; i++) begin
      classic(1'b0, 32'(i * 4), 32'h0, 4'hF, rd);
      chk("post_rst", rd, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
